ram_io_responder: RTL and testbench
===================================

# ram_io_responder

Byte-wide memory responder on the far end of the memory controller's RAM bus. It serves the controller's one-byte-per-cycle address/data/write stream from on-chip RAM and maps a small I/O window (byte port at 0x30000, status at 0x30004) onto two FIFOs. The transmit FIFO feeds an external serial sink; the receive FIFO is filled by an external source. It sits between the memory controller and the RAM/UART side of the top level.

## Interface
- ADDR_WIDTH, 17: RAM is 2^ADDR_WIDTH bytes at address 0.
- FIFO_DEPTH_LOG2, 3: each FIFO holds 2^FIFO_DEPTH_LOG2 bytes.
- IO_ADDR, 32'h30000: I/O data port; the status register is at IO_ADDR+4.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- mem_a  in  32  byte address from the controller, sampled every posedge.
- mem_dout  in  8  write byte from the controller.
- mem_wr  in  1  1 = write, 0 = read.
- mem_din  out  8  registered read byte to the controller's din.
- io_tx_valid  out  1  tx FIFO non-empty.
- io_tx_data  out  8  tx FIFO head byte.
- io_tx_ready  in  1  sink accepts the head byte this edge.
- io_rx_valid  in  1  source offers io_rx_data.
- io_rx_data  in  8  incoming byte.
- io_rx_ready  out  1  rx FIFO not full.

## Operation
- Each posedge performs exactly one access. There is no request strobe; a held address repeats the access.
- Address decode, in priority order:
  - mem_a == IO_ADDR: data port.
  - mem_a == IO_ADDR+4: status register.
  - mem_a < 2^ADDR_WIDTH: RAM.
  - Otherwise: unmapped.
- RAM write: byte mem_dout is stored at mem_a[ADDR_WIDTH-1:0]. RAM contents are not reset.
- RAM read: mem_din <= ram[mem_a].
- Data port write: pushes mem_dout into the tx FIFO. If the tx FIFO is full, the byte is dropped and the sticky overflow flag is set.
- Data port read: if the rx FIFO is non-empty, mem_din <= head and the head is popped. If it is empty, mem_din <= 8'h00 and nothing is popped.
- Status read returns {5'b0, overflow, tx_full, rx_nonempty}, with values as before the edge. The same edge clears overflow unless an overflowing write occurs at that edge (it cannot, since only one access per cycle).
- Status writes are ignored.
- Unmapped access: writes are ignored; reads give mem_din <= 8'h00.
- Tx FIFO drains when io_tx_valid && io_tx_ready at an edge.
- Rx FIFO fills when io_rx_valid && io_rx_ready at an edge.
- FIFOs are circular with (FIFO_DEPTH_LOG2+1)-bit read/write pointers; the MSB distinguishes full from empty. Pointers wrap modulo 2^(FIFO_DEPTH_LOG2+1).
- Simultaneous push and pop on the same FIFO:
  - Non-empty and not full: both occur and the count is unchanged.
  - Empty: the push occurs; the pop is not possible because valid/ready is evaluated before the edge.
  - Full: both occur. The pop frees a slot, so the push is accepted only if the pop also happens at that edge. For tx this applies to a CPU write while full and io_tx_ready=1; for rx it does not apply, because io_rx_ready = !full before the edge.

## Timing
- Read latency is 1 cycle: an address sampled at edge k gives mem_din valid from just after edge k until edge k+1. The controller reads din in the cycle after presenting the address.
- Write takes effect at the sampling edge. A read of the same address at edge k+1 returns the new byte.
- io_tx_valid, io_tx_data and io_rx_ready are decoded combinationally from FIFO state registers only; there is no combinational path from mem_* or io_*_valid/ready.
- Reset (rst=0, asynchronous):
  - mem_din=0, both FIFOs empty, overflow=0.
  - Hence io_tx_valid=0, io_tx_data=0, io_rx_ready=1.
- Reset asserted mid-stream discards all FIFO contents immediately. RAM contents are preserved.
- The first access is at the first posedge with rst=1.

## Test plan
- RAM write/read: write 0xA5 @0x00010 and 0x3C @0x00011, then read 0x10 and 0x11 back-to-back -> mem_din = A5 then 3C, each one cycle after its address.
- Read-after-write: write 0x77 @0x1FFFF at edge k, read 0x1FFFF at edge k+1 -> mem_din = 77 after edge k+1. Read 0x20000 (unmapped) -> 00.
- Tx path, with io_tx_ready=0: write 0x41..0x48 to 0x30000 (8 bytes) -> status = 0x02. A 9th write of 0x49 -> status read = 0x06, then the next status read = 0x02. With io_tx_ready=1 -> io_tx_data sequence 41..48, then io_tx_valid=0.
- Rx path: source pushes 0x10, 0x20 -> status = 0x01. Data reads -> 10, 20, then 00, with final status = 0x00. Push 9 bytes with no reads -> io_rx_ready=0 after the 8th.
- Simultaneous on full tx: tx full, io_tx_ready=1, CPU writes 0x99 at the same edge -> head advances, 0x99 is accepted as the 8th entry, overflow stays 0.
- Async reset: assert rst=0 mid-cycle with both FIFOs non-empty -> io_tx_valid=0, io_rx_ready=1 and mem_din=00 immediately, without waiting for a clock edge. A RAM byte written before reset reads back unchanged.

Source files
------------

// File: rtl/ram_io_responder.sv
// Byte-wide RAM responder for the memory controller's bus, with a two-register I/O window
// (data port, status) mapped onto a transmit FIFO and a receive FIFO.
module ram_io_responder #(
    parameter int unsigned ADDR_WIDTH      = 17,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3,
    parameter logic [31:0] IO_ADDR         = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_tx_valid,
    output logic [7:0]  io_tx_data,
    input  logic        io_tx_ready,
    input  logic        io_rx_valid,
    input  logic [7:0]  io_rx_data,
    output logic        io_rx_ready
);

    localparam int unsigned DEPTH       = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PW          = FIFO_DEPTH_LOG2 + 1;
    localparam logic [31:0] STATUS_ADDR = IO_ADDR + 32'd4;

    typedef enum logic [1:0] {SEL_DATA, SEL_STATUS, SEL_RAM, SEL_NONE} sel_t;

    sel_t                  sel;
    logic [7:0]            ram    [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0]            tx_mem [0:DEPTH - 1];
    logic [7:0]            rx_mem [0:DEPTH - 1];
    logic [PW-1:0]         tx_wr, tx_rd, rx_wr, rx_rd;
    logic                  overflow;
    logic                  tx_empty, tx_full, rx_empty, rx_full;
    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic                  ovf_set, status_rd, ram_we;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [7:0]            rd_data;

    always_comb begin
        if (mem_a == IO_ADDR)                sel = SEL_DATA;
        else if (mem_a == STATUS_ADDR)       sel = SEL_STATUS;
        else if (mem_a[31:ADDR_WIDTH] == '0) sel = SEL_RAM;
        else                                 sel = SEL_NONE;
    end

    assign ram_idx = mem_a[ADDR_WIDTH-1:0];
    assign ram_we  = (sel == SEL_RAM) && mem_wr;

    // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[PW-1] != tx_rd[PW-1]) && (tx_wr[PW-2:0] == tx_rd[PW-2:0]);
    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[PW-1] != rx_rd[PW-1]) && (rx_wr[PW-2:0] == rx_rd[PW-2:0]);

    // A pop on a full tx FIFO frees the slot that a same-edge CPU write lands in.
    assign tx_pop    = !tx_empty && io_tx_ready;
    assign tx_push   = (sel == SEL_DATA) && mem_wr && (!tx_full || tx_pop);
    assign ovf_set   = (sel == SEL_DATA) && mem_wr && tx_full && !tx_pop;
    assign rx_pop    = (sel == SEL_DATA) && !mem_wr && !rx_empty;
    assign rx_push   = io_rx_valid && !rx_full;
    assign status_rd = (sel == SEL_STATUS) && !mem_wr;

    assign io_tx_valid = !tx_empty;
    assign io_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd[PW-2:0]];
    assign io_rx_ready = !rx_full;

    always_comb begin
        rd_data = 8'h00;
        case (sel)
            SEL_DATA:   rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd[PW-2:0]];
            SEL_STATUS: rd_data = {5'b0, overflow, tx_full, !rx_empty};
            SEL_RAM:    rd_data = ram[ram_idx];
            default:    rd_data = 8'h00;
        endcase
    end

    // NOTE: storage arrays carry no reset; only pointers and flags are reset, which empties the FIFOs.
    always_ff @(posedge clk) begin
        if (rst && ram_we)  ram[ram_idx]          <= mem_dout;
        if (rst && tx_push) tx_mem[tx_wr[PW-2:0]] <= mem_dout;
        if (rst && rx_push) rx_mem[rx_wr[PW-2:0]] <= io_rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_din  <= 8'h00;
            tx_wr    <= '0;
            tx_rd    <= '0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            overflow <= 1'b0;
        end else begin
            if (!mem_wr) mem_din <= rd_data;
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            if (ovf_set)        overflow <= 1'b1;
            else if (status_rd) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Randomized bench for ram_io_responder, checked against a queue/array model of the bus
// map, the two FIFOs and the sticky overflow flag.
module tb_ram_io_responder;

    localparam logic [31:0] IO   = 32'h0003_0000;
    localparam logic [31:0] ST   = 32'h0003_0004;
    localparam logic [31:0] IDLE = 32'h0004_0000;

    logic        clk, rst;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout, mem_din, io_tx_data, io_rx_data;
    logic        mem_wr, io_tx_valid, io_tx_ready, io_rx_valid, io_rx_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram_m [int];
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic       ovf_m;

    ram_io_responder dut (
        .clk(clk), .rst(rst), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .io_tx_valid(io_tx_valid), .io_tx_data(io_tx_data),
        .io_tx_ready(io_tx_ready), .io_rx_valid(io_rx_valid), .io_rx_data(io_rx_data),
        .io_rx_ready(io_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus access plus FIFO-side traffic; the model predicts the edge, then outputs are compared.
    task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                        input logic txr, input logic rxv, input logic [7:0] rxd);
        logic [7:0] exp;
        logic       known, full_pre, rx_ne_pre, tx_pop, rx_push;
        mem_a = a; mem_wr = wr; mem_dout = d;
        io_tx_ready = txr; io_rx_valid = rxv; io_rx_data = rxd;
        known     = 1'b0;
        exp       = 8'h00;
        full_pre  = (tx_q.size() == 8);
        rx_ne_pre = (rx_q.size() > 0);
        tx_pop    = (tx_q.size() > 0) && txr;
        rx_push   = rxv && (rx_q.size() < 8);
        if (tx_pop) void'(tx_q.pop_front());
        if (a == IO) begin
            if (wr) begin
                if (!full_pre || tx_pop) tx_q.push_back(d);
                else                     ovf_m = 1'b1;
            end else begin
                known = 1'b1;
                if (rx_ne_pre) exp = rx_q.pop_front();
            end
        end else if (a == ST) begin
            if (!wr) begin
                known = 1'b1;
                exp   = {5'b0, ovf_m, full_pre, rx_ne_pre};
                ovf_m = 1'b0;
            end
        end else if (a < 32'h0002_0000) begin
            if (wr) ram_m[int'(a)] = d;
            else if (ram_m.exists(int'(a))) begin
                known = 1'b1;
                exp   = ram_m[int'(a)];
            end
        end else if (!wr) begin
            known = 1'b1;
        end
        if (rx_push) rx_q.push_back(rxd);
        @(posedge clk);
        #1;
        if (known) begin
            checks++;
            if (mem_din !== exp) begin
                errors++;
                $display("FAIL din @%h: got %h expected %h", a, mem_din, exp);
            end
        end
        checks++;
        if (io_tx_valid !== (tx_q.size() > 0)) begin
            errors++;
            $display("FAIL tx_valid: got %b expected %b", io_tx_valid, tx_q.size() > 0);
        end
        checks++;
        if (io_tx_data !== ((tx_q.size() > 0) ? tx_q[0] : 8'h00)) begin
            errors++;
            $display("FAIL tx_data: got %h expected %h", io_tx_data,
                     (tx_q.size() > 0) ? tx_q[0] : 8'h00);
        end
        checks++;
        if (io_rx_ready !== (rx_q.size() < 8)) begin
            errors++;
            $display("FAIL rx_ready: got %b expected %b", io_rx_ready, rx_q.size() < 8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_a = IDLE; mem_wr = 1'b0; mem_dout = 8'h00;
        io_tx_ready = 1'b0; io_rx_valid = 1'b0; io_rx_data = 8'h00;
        tx_q.delete(); rx_q.delete(); ovf_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_din !== 8'h00 || io_tx_valid !== 1'b0 || io_tx_data !== 8'h00 || io_rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got din=%h txv=%b txd=%h rxr=%b expected 00 0 00 1",
                     mem_din, io_tx_valid, io_tx_data, io_rx_ready);
        end
        rst = 1'b1;
    endtask

    task automatic test_ram();
        step(32'h10, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
        step(32'h11, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
        step(32'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_rd_10: got %h expected a5", mem_din); end
        step(32'h11, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h3C) begin errors++; $display("FAIL ram_rd_11: got %h expected 3c", mem_din); end
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 255)) + (($urandom_range(0, 1) == 1) ? 32'h1FF00 : 32'h0);
            step(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic test_read_after_write();
        step(32'h1FFFF, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
        step(32'h1FFFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h77) begin errors++; $display("FAIL raw_1ffff: got %h expected 77", mem_din); end
        step(32'h20000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h00) begin errors++; $display("FAIL unmapped_20000: got %h expected 00", mem_din); end
        step(32'h10, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
        step(32'h20010, 1'b1, 8'hEE, 1'b0, 1'b0, 8'h00);
        step(32'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'hA5) begin errors++; $display("FAIL unmapped_alias: got %h expected a5", mem_din); end
        step(ST, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
        step(ST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h00) begin errors++; $display("FAIL status_idle: got %h expected 00", mem_din); end
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a;
            a = 32'h0002_0000 | $urandom;
            if (a == IO || a == ST) a = IDLE;
            step(a, 1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
            step(a, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic test_tx();
        for (int i = 0; i < 8; i++) step(IO, 1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 8'h00);
        step(ST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h02) begin errors++; $display("FAIL tx_full_status: got %h expected 02", mem_din); end
        step(IO, 1'b1, 8'h49, 1'b0, 1'b0, 8'h00);
        step(ST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h06) begin errors++; $display("FAIL tx_ovf_status: got %h expected 06", mem_din); end
        step(ST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h02) begin errors++; $display("FAIL tx_ovf_cleared: got %h expected 02", mem_din); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (io_tx_valid !== 1'b1 || io_tx_data !== 8'h41 + 8'(i)) begin
                errors++;
                $display("FAIL tx_drain_%0d: got v=%b d=%h expected 1 %h", i, io_tx_valid, io_tx_data, 8'h41 + 8'(i));
            end
            step(IDLE, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        end
        checks++;
        if (io_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty: got %b expected 0", io_tx_valid); end
    endtask

    task automatic test_rx();
        step(IDLE, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10);
        step(IDLE, 1'b0, 8'h00, 1'b0, 1'b1, 8'h20);
        step(ST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h01) begin errors++; $display("FAIL rx_status: got %h expected 01", mem_din); end
        step(IO, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h10) begin errors++; $display("FAIL rx_rd0: got %h expected 10", mem_din); end
        step(IO, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h20) begin errors++; $display("FAIL rx_rd1: got %h expected 20", mem_din); end
        step(IO, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_rd_empty: got %h expected 00", mem_din); end
        step(ST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_status_empty: got %h expected 00", mem_din); end
        for (int i = 0; i < 9; i++) begin
            step(IDLE, 1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom));
            if (i == 7) begin
                checks++;
                if (io_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b expected 0", io_rx_ready); end
            end
        end
        for (int i = 0; i < 8; i++) step(IO, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        step(ST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_drained_status: got %h expected 00", mem_din); end
    endtask

    task automatic test_back_to_back_full();
        logic [7:0] want [8];
        for (int i = 0; i < 8; i++) step(IO, 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 8'h00);
        step(IO, 1'b1, 8'h99, 1'b1, 1'b0, 8'h00);
        step(ST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h02) begin errors++; $display("FAIL simul_status: got %h expected 02", mem_din); end
        for (int i = 0; i < 7; i++) want[i] = 8'h51 + 8'(i);
        want[7] = 8'h99;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (io_tx_data !== want[i]) begin
                errors++;
                $display("FAIL simul_drain_%0d: got %h expected %h", i, io_tx_data, want[i]);
            end
            step(IDLE, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            logic [31:0] a;
            int op;
            op = $urandom_range(0, 4);
            case (op)
                0, 1:    a = IO;
                2:       a = ST;
                3:       a = 32'($urandom_range(0, 31));
                default: a = IDLE;
            endcase
            step(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom));
        end
    endtask

    task automatic test_async_reset();
        step(32'h123, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(IO, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1, 8'hD0 + 8'(i));
        step(32'h123, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        #2;
        rst = 1'b0;
        tx_q.delete(); rx_q.delete(); ovf_m = 1'b0;
        #1;
        checks++;
        if (io_tx_valid !== 1'b0 || io_tx_data !== 8'h00 || io_rx_ready !== 1'b1 || mem_din !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got txv=%b txd=%h rxr=%b din=%h expected 0 00 1 00",
                     io_tx_valid, io_tx_data, io_rx_ready, mem_din);
        end
        #2;
        rst = 1'b1;
        step(32'h123, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h5A) begin errors++; $display("FAIL ram_kept: got %h expected 5a", mem_din); end
        step(ST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_din !== 8'h00) begin errors++; $display("FAIL status_after_reset: got %h expected 00", mem_din); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_read_after_write();
        test_tx();
        test_rx();
        test_back_to_back_full();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
